clk_div_bank: RTL
=================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent divider channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16: divisor and counter width in bits.
REQ-003 SHALL have parameter DIV_RESET, default 16: divisor loaded into every channel at reset.
REQ-004 SHALL have port clk  input  1  single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port lock  input  1  PLL lock; 0 freezes all channels.
REQ-007 SHALL have port en  input  CHANNELS  per-channel run enable.
REQ-008 SHALL have port wr_en  input  1  divisor write strobe.
REQ-009 SHALL have port wr_ch  input  3  target channel index for the write.
REQ-010 SHALL have port wr_div  input  CNT_W  new divisor value.
REQ-011 SHALL have port tick  output  CHANNELS  one-cycle strobe per divided period.
REQ-012 SHALL have port clk_out  output  CHANNELS  divided square wave, usable as data or enable only, never as a clock.
REQ-013 SHALL have port pending  output  CHANNELS  shadow divisor not yet applied.

Function
REQ-014 Each channel SHALL hold cnt (CNT_W), active divisor div, shadow divisor shd and a pending flag.
REQ-015 A divisor value of 0 SHALL be treated as 1 wherever it is used.
REQ-016 A channel SHALL run only when lock=1 and en[i]=1.
REQ-017 While running, cnt SHALL increment by 1 each cycle and wrap to 0 after reaching div-1.
REQ-018 tick[i] SHALL be registered and SHALL be 1 in the cycle after cnt==div-1 while running; for div=1 it SHALL be 1 every running cycle.
REQ-019 clk_out[i] SHALL be registered and SHALL equal (cnt < (div>>1)) with one cycle latency while running.
REQ-020 For odd div, clk_out high time SHALL be floor(div/2) cycles; for div=1, clk_out SHALL stay 0.
REQ-021 While not running, cnt SHALL hold at 0 and tick and clk_out SHALL be driven 0 on the next cycle.
REQ-022 A write with wr_en=1 and wr_ch<CHANNELS SHALL load shd of channel wr_ch and set its pending flag on the next edge.
REQ-023 A write with wr_ch>=CHANNELS SHALL be ignored.
REQ-024 A running channel with pending=1 SHALL copy shd into div at the cycle cnt wraps to 0 and clear pending, so no truncated or stretched period occurs.
REQ-025 A write in the same cycle as a wrap SHALL NOT be applied at that wrap; it SHALL be applied at the next wrap.
REQ-026 A channel that is not running SHALL apply a pending shd on the next cycle and clear pending.
REQ-027 A second write while pending=1 SHALL overwrite shd; only the last value is applied.
REQ-028 Writes SHALL be accepted regardless of lock and en.
REQ-029 When a channel resumes (lock and en both rise), counting SHALL start from cnt=0, with the first tick div cycles later.
REQ-030 Channels SHALL be fully independent; writes to one channel SHALL NOT disturb the phase of another.

Reset
REQ-031 With rst=1 at an edge, every channel SHALL set cnt=0, div=shd=DIV_RESET, pending=0, tick=0 and clk_out=0.
REQ-032 rst SHALL take priority over writes, lock and en in the same cycle.
REQ-033 rst mid-period SHALL discard any pending divisor.

Verification
REQ-034 Reset, then lock=1 and en=all -> each tick period is 16 cycles; clk_out is 8 cycles high and 8 low.
REQ-035 Write ch1 div=5 mid-period -> pending[1]=1; the current 16-cycle period completes; the next periods are 5 cycles with clk_out 2 high / 3 low; pending clears at the wrap.
REQ-036 Write div=0 and div=1 -> tick is asserted every cycle; clk_out stays 0.
REQ-037 Drop lock for 7 cycles mid-period, then raise it -> tick and clk_out go 0 within 1 cycle; the first tick arrives div cycles after lock rises.
REQ-038 Write issued in the same cycle as ch0 wrap, wr_ch=5 with CHANNELS=3, and rst asserted while pending -> the write applies one period later; the invalid channel write causes no state change; rst restores DIV_RESET with pending=0.

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock-enable dividers. Each channel produces a
// tick strobe and a square-wave enable, with glitch-free divisor updates at period boundaries.
module clk_div_bank #(
    parameter int CHANNELS  = 3,
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lock,
    input  logic [CHANNELS-1:0] en,
    input  logic                wr_en,
    input  logic [2:0]          wr_ch,
    input  logic [CNT_W-1:0]    wr_div,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] pending
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] shd_q, shd_d;
        logic             pend_q, pend_d;
        logic             tick_q, tick_d;
        logic             clko_q, clko_d;
        logic [CNT_W-1:0] div_eff;
        logic             run;
        logic             wrap;
        logic             wr_hit;

        always_comb begin
            div_eff = (div_q == '0) ? CNT_W'(1) : div_q;
            run     = lock & en[gi];
            wrap    = (cnt_q >= div_eff - CNT_W'(1));
            // Out-of-range channel indices never match any gi, so they are dropped here.
            wr_hit  = wr_en && (wr_ch == 3'(gi));

            cnt_d  = cnt_q;
            div_d  = div_q;
            shd_d  = shd_q;
            pend_d = pend_q;
            tick_d = 1'b0;
            clko_d = 1'b0;

            if (run) begin
                cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
                tick_d = wrap;
                clko_d = (cnt_q < (div_eff >> 1));
                if (wrap && pend_q) begin
                    div_d  = shd_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = '0;
                if (pend_q) begin
                    div_d  = shd_q;
                    pend_d = 1'b0;
                end
            end

            // A write in the same cycle as an apply re-arms pending for the next boundary.
            if (wr_hit) begin
                shd_d  = wr_div;
                pend_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                div_q  <= CNT_W'(DIV_RESET);
                shd_q  <= CNT_W'(DIV_RESET);
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                clko_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                shd_q  <= shd_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
                clko_q <= clko_d;
            end
        end

        assign tick[gi]    = tick_q;
        assign clk_out[gi] = clko_q;
        assign pending[gi] = pend_q;
    end

endmodule
